// File: rtl/booth_mult_seq_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier family.
// Sizes depend on WIDTH, so modules derive theirs through the helper functions.
package mult_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

  function automatic int acc_width(input int w);
    return 2 * (w + 1) + 1;
  endfunction

  // Sizes for the default 32-bit MULT/MULTU datapath.
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = cnt_width(WIDTH_DEF);
  localparam int ACC_W     = acc_width(WIDTH_DEF);

endpackage

// File: rtl/booth_mult_seq_if.sv
// Request/result bundle between the CPU control unit (master) and the multiplier (slave).
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/booth_mult_seq_step.sv
// One radix-2 Booth step: conditional add/subtract into P_hi, then arithmetic shift right by one.
// Accumulator layout is {P_hi[WIDTH:0], P_lo[WIDTH:0], q}.
module booth_r2_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [acc_width(WIDTH)-1:0] acc,
  input  logic [WIDTH:0]              mcand,
  input  logic [WIDTH:0]              neg_mcand,
  output logic [acc_width(WIDTH)-1:0] acc_next
);
  localparam int AW = acc_width(WIDTH);

  logic [WIDTH:0] p_hi;
  logic [WIDTH:0] p_hi_new;

  assign p_hi = acc[AW-1 -: WIDTH+1];

  always_comb begin
    p_hi_new = p_hi;
    case (acc[1:0])
      2'b01:   p_hi_new = p_hi + mcand;
      2'b10:   p_hi_new = p_hi + neg_mcand;
      default: p_hi_new = p_hi;
    endcase
  end

  // Shifting drops the old q; P_lo[0] becomes the next q.
  assign acc_next = {p_hi_new[WIDTH], p_hi_new, acc[WIDTH+1:1]};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier for MULT/MULTU: WIDTH+1 steps, signed or unsigned,
// with optional one-cycle completion when either operand is zero.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  booth_mult_seq_if.slave   bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam int AW = acc_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_next;
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   neg_mcand;
  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // One extra bit lets the same signed datapath handle MULTU and the most-negative operands.
  assign ext_a = {bus.is_signed & bus.op_a[WIDTH-1], bus.op_a};
  assign ext_b = {bus.is_signed & bus.op_b[WIDTH-1], bus.op_b};

  booth_r2_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .mcand     (mcand),
    .neg_mcand (neg_mcand),
    .acc_next  (acc_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      neg_mcand <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (EARLY_ZERO && (bus.op_a == '0 || bus.op_b == '0)) begin
              hi_q   <= '0;
              lo_q   <= '0;
              done_q <= 1'b1;
            end else begin
              mcand     <= ext_a;
              neg_mcand <= -ext_a;
              acc       <= {{(WIDTH+1){1'b0}}, ext_b, 1'b0};
              count     <= '0;
              busy_q    <= 1'b1;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          // Final step: the product is the low 2*WIDTH bits of {P_hi, P_lo}.
          if (count == CW'(WIDTH)) begin
            hi_q   <= acc_next[2*WIDTH:WIDTH+1];
            lo_q   <= acc_next[WIDTH:1];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: one instance with zero early-out, one with fixed latency.
module tb_booth_mult_seq;
  logic clock;
  logic reset;
  int   checks;
  int   passes;

  booth_mult_seq_if #(.WIDTH(32)) b0 ();
  booth_mult_seq_if #(.WIDTH(32)) b1 ();

  booth_mult_seq #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut_ez (
    .clock (clock),
    .reset (reset),
    .bus   (b0.slave)
  );

  booth_mult_seq #(.WIDTH(32), .EARLY_ZERO(1'b0)) dut_fixed (
    .clock (clock),
    .reset (reset),
    .bus   (b1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit which, input bit st, input bit sg,
                       input logic [31:0] a, input logic [31:0] b);
    if (which) begin
      b1.start = st; b1.is_signed = sg; b1.op_a = a; b1.op_b = b;
    end else begin
      b0.start = st; b0.is_signed = sg; b0.op_a = a; b0.op_b = b;
    end
  endtask

  // Issue one multiply, then measure edges from acceptance to done and busy cycles.
  task automatic do_mult(input string tag, input bit which, input bit sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    int busy_cnt;
    drive(which, 1'b1, sg, a, b);
    tick();
    drive(which, 1'b0, 1'b0, 32'h0, 32'h0);
    lat = 0;
    busy_cnt = 0;
    while (!(which ? b1.done : b0.done) && lat < 100) begin
      if (which ? b1.busy : b0.busy) busy_cnt++;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
    chk({tag, " hi"}, 64'(which ? b1.hi : b0.hi), 64'(eh));
    chk({tag, " lo"}, 64'(which ? b1.lo : b0.lo), 64'(el));
    tick();
    chk({tag, " done one cycle"}, 64'(which ? b1.done : b0.done), 64'd0);
  endtask

  initial begin
    int n;
    int cnt;
    checks = 0;
    passes = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    chk("reset busy", 64'(b0.busy), 64'd0);
    chk("reset done", 64'(b0.done), 64'd0);
    chk("reset hi",   64'(b0.hi),   64'd0);
    chk("reset lo",   64'(b0.lo),   64'd0);
    chk("reset fixed busy", 64'(b1.busy), 64'd0);
    tick();

    do_mult("s 3*5",        1'b0, 1'b1, 32'd3,        32'd5,        33, 32'h0,        32'hF);
    do_mult("s -1*-1",      1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h0,        32'h1);
    do_mult("u max*max",    1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h1);
    do_mult("s min*min",    1'b0, 1'b1, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0);
    do_mult("s min*1",      1'b0, 1'b1, 32'h80000000, 32'd1,        33, 32'hFFFFFFFF, 32'h80000000);
    do_mult("ez 0*1234",    1'b0, 1'b1, 32'h0,        32'h1234,     0,  32'h0,        32'h0);
    do_mult("fixed 7*6",    1'b1, 1'b1, 32'd7,        32'd6,        33, 32'h0,        32'd42);
    do_mult("fixed 0*1234", 1'b1, 1'b1, 32'h0,        32'h1234,     33, 32'h0,        32'h0);

    // Start held high: second request lands in the done cycle.
    drive(1'b0, 1'b1, 1'b1, 32'd7, 32'd6);
    tick();
    b0.op_a = 32'hFFFFFFF9;
    n = 0;
    while (!b0.done && n < 100) begin tick(); n++; end
    chk("b2b first latency", 64'(n), 64'd33);
    chk("b2b first hi", 64'(b0.hi), 64'h0);
    chk("b2b first lo", 64'(b0.lo), 64'd42);
    n = 0;
    do begin tick(); n++; end while (!b0.done && n < 100);
    chk("b2b spacing", 64'(n), 64'd34);
    chk("b2b second hi", 64'(b0.hi), 64'hFFFFFFFF);
    chk("b2b second lo", 64'(b0.lo), 64'hFFFFFFD6);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // A start pulse mid-RUN must not disturb the operation or queue another.
    drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd5);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    drive(1'b0, 1'b1, 1'b0, 32'd100, 32'd100);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n = 11;
    while (!b0.done && n < 100) begin tick(); n++; end
    chk("toggle latency", 64'(n), 64'd33);
    chk("toggle lo", 64'(b0.lo), 64'hF);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b0.busy || b0.done) cnt++;
    end
    chk("toggle no queued op", 64'(cnt), 64'd0);

    // Reset mid-operation discards the in-flight result.
    drive(1'b0, 1'b1, 1'b1, 32'd9, 32'd9);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst busy", 64'(b0.busy), 64'd0);
    chk("midrst done", 64'(b0.done), 64'd0);
    chk("midrst hi",   64'(b0.hi),   64'd0);
    chk("midrst lo",   64'(b0.lo),   64'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b0.done) cnt++;
    end
    chk("midrst no done", 64'(cnt), 64'd0);
    do_mult("after rst 2*3", 1'b0, 1'b1, 32'd2, 32'd3, 33, 32'h0, 32'd6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier for the CPU's MULT/MULTU path, producing a 2*WIDTH-bit product into the HI and LO registers. It is the successor of the fixed 32-bit signed multiplier. New features:
- WIDTH parameter
- signed/unsigned mode
- explicit start/busy/done handshake with back-to-back issue
- optional zero-operand early completion
The control unit pulses start and stalls on busy.

Parameters:
WIDTH, 32, operand width in bits (>= 4)
EARLY_ZERO, 1, 1 = complete in one cycle when either operand is zero; 0 = fixed latency always

Ports:
clock  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
op_a  input  WIDTH  multiplicand; sampled with start
op_b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse: hi/lo updated on this cycle
hi  output  WIDTH  upper half of product; holds until next completion
lo  output  WIDTH  lower half of product; holds until next completion

Behaviour:
- Reset (reset high at a rising edge) values:
  - state = IDLE
  - busy = 0, done = 0, hi = 0, lo = 0
  - counter and accumulator = 0
  - Applies at any time, including mid-operation; the in-flight result is discarded.
- States: IDLE, RUN. done is a registered pulse, not a separate state.
- IDLE, start=1 at edge k:
  - Latch operands extended to WIDTH+1 bits: sign-extend if is_signed, zero-extend otherwise.
  - Accumulator {P_hi(WIDTH+1), P_lo(WIDTH+1), q(1)} = {0, ext(op_b), 0}.
  - Keep ext(op_a) and its negation (WIDTH+1 bits).
  - count = 0; busy = 1; go to RUN.
- EARLY_ZERO=1 and (op_a==0 or op_b==0) at edge k:
  - Skip RUN and stay in IDLE.
  - hi = 0, lo = 0, done = 1 at edge k, so done is high the cycle after the start cycle.
  - busy stays 0.
- RUN, each edge performs one Booth step on the pair {P_lo[0], q}:
  - 01: P_hi += ext(op_a)
  - 10: P_hi -= ext(op_a)
  - 00/11: no add
  - Then arithmetic shift right of the whole accumulator by 1; count += 1.
- Completion: the edge performing step WIDTH+1 (count == WIDTH before the step):
  - Product = low 2*WIDTH bits of {P_hi, P_lo} after the step.
  - hi = product[2W-1:W], lo = product[W-1:0].
  - done = 1, busy = 0, state goes to IDLE.
  - Latency: WIDTH+1 edges after the accepting edge (33 for WIDTH=32), identical for signed and unsigned.
- done is high for exactly one cycle, then returns to 0 unless a new completion occurs.
- start while busy=1 is ignored; no queueing.
- start in the cycle where done=1 (state IDLE) is accepted: back-to-back throughput is one result per WIDTH+2 cycles.
- Operand inputs may change freely after the accepting edge.
- Arithmetic widths: adder WIDTH+1 bits, wrap ignored. The WIDTH+1 extension makes both signed and unsigned full-range products exact, including -2^(W-1) * -2^(W-1).
- hi/lo never change except on reset or completion.

Decomposition:
- Package mult_pkg:
  - state enum {IDLE, RUN}
  - localparam CNT_W = $clog2(WIDTH+2)
  - localparam ACC_W = 2*(WIDTH+1)+1
- Sub-module booth_r2_step, purely combinational:
  - inputs: accumulator, ext multiplicand, negated multiplicand
  - output: next accumulator (add/sub + arithmetic shift)
  - Instantiated once in booth_mult_seq and reusable by a future radix-4 variant.

Test Plan:
- reset; start with is_signed=1, a=3, b=5 -> busy for 33 cycles; done pulse on the 33rd edge after acceptance; hi=0x00000000, lo=0x0000000F.
- is_signed=1, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001. Repeat with is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
- is_signed=1, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- EARLY_ZERO=1, a=0, b=0x1234 -> done on the next edge, busy never 1, hi=lo=0. With EARLY_ZERO=0 the same operands -> 33-cycle latency, hi=lo=0.
- Back-to-back and ignore-while-busy:
  - start held high continuously with 7*6 then -7*6 -> two done pulses 34 cycles apart; lo=42, then hi=0xFFFFFFFF, lo=0xFFFFFFD6.
  - A start toggled mid-RUN is ignored.
- After one completed multiply (hi/lo nonzero), a second operation with reset asserted 10 cycles after acceptance -> next cycle busy=0, done=0, hi=lo=0. No done pulse follows; a fresh start then completes normally.
